// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: opcodes, FSM states,
// lane offsets and small decode helpers.
package load_store_unit_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'b000,
    OP_LH  = 3'b001,
    OP_LHU = 3'b010,
    OP_LB  = 3'b011,
    OP_LBU = 3'b100,
    OP_SW  = 3'b101,
    OP_SH  = 3'b110,
    OP_SB  = 3'b111
  } lsu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CAP  = 2'd2,
    WR   = 2'd3
  } lsu_state_e;

  // Big-endian lanes: byte offset 0 is the most significant byte.
  localparam logic [1:0] LANE_BYTE0   = 2'd0;
  localparam logic [1:0] LANE_BYTE1   = 2'd1;
  localparam logic [1:0] LANE_BYTE2   = 2'd2;
  localparam logic [1:0] LANE_BYTE3   = 2'd3;
  localparam logic [1:0] LANE_HALF_HI = 2'd0;
  localparam logic [1:0] LANE_HALF_LO = 2'd2;

  function automatic logic isMisaligned(input lsu_op_e op, input logic [1:0] offset);
    case (op)
      OP_LW, OP_SW:        return offset != 2'b00;
      OP_LH, OP_LHU, OP_SH: return offset[0];
      default:             return 1'b0;
    endcase
  endfunction

  function automatic logic isLoad(input lsu_op_e op);
    case (op)
      OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_lane.sv
// Lane steering for the load/store unit: picks the addressed byte/half
// out of a memory word for loads and merges store data into a word for
// read-modify-write stores.
module lsu_lane
  import load_store_unit_pkg::*;
(
  input  lsu_op_e     op_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] word_i,
  input  logic [15:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  laneByte;
  logic [15:0] laneHalf;

  // Select the addressed byte and half from the memory word.
  always_comb begin
    laneByte = word_i[31:24];
    case (offset_i)
      LANE_BYTE1: laneByte = word_i[23:16];
      LANE_BYTE2: laneByte = word_i[15:8];
      LANE_BYTE3: laneByte = word_i[7:0];
      default:    laneByte = word_i[31:24];
    endcase
    laneHalf = (offset_i == LANE_HALF_LO) ? word_i[15:0] : word_i[31:16];
  end

  // Sign- or zero-extend the selected lane into the load result.
  always_comb begin
    load_o = word_i;
    case (op_i)
      OP_LH:   load_o = {{16{laneHalf[15]}}, laneHalf};
      OP_LHU:  load_o = {16'h0000, laneHalf};
      OP_LB:   load_o = {{24{laneByte[7]}}, laneByte};
      OP_LBU:  load_o = {24'h000000, laneByte};
      default: load_o = word_i;
    endcase
  end

  // Replace the addressed lane of the old word with the store data.
  always_comb begin
    merge_o = word_i;
    case (op_i)
      OP_SH: begin
        if (offset_i == LANE_HALF_LO) merge_o[15:0] = wdata_i;
        else merge_o[31:16] = wdata_i;
      end
      OP_SB: begin
        case (offset_i)
          LANE_BYTE0: merge_o[31:24] = wdata_i[7:0];
          LANE_BYTE1: merge_o[23:16] = wdata_i[7:0];
          LANE_BYTE2: merge_o[15:8]  = wdata_i[7:0];
          default:    merge_o[7:0]   = wdata_i[7:0];
        endcase
      end
      default: merge_o = word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between a CPU and a word-wide big-endian data memory.
// Word stores go straight to memory; sub-word stores read, merge and
// write back. All outputs except ready come from registers.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        state_q;
  lsu_op_e           op_q;
  logic [1:0]        offset_q;
  logic [15:0]       wdata_q;
  logic              done_q;
  logic              err_q;
  logic [31:0]       rdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              mem_write_q;
  logic              mem_read_q;

  lsu_op_e     reqOp;
  logic [31:0] laneLoad;
  logic [31:0] laneMerge;

  assign reqOp = lsu_op_e'(op);

  lsu_lane u_lane (
    .op_i     (op_q),
    .offset_i (offset_q),
    .word_i   (mem_rdata),
    .wdata_i  (wdata_q),
    .load_o   (laneLoad),
    .merge_o  (laneMerge)
  );

  // Access sequencer: accept in IDLE, read in RD, extract or merge in CAP,
  // write in WR; done is a one-cycle pulse landing back in IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= OP_LW;
      offset_q    <= 2'b00;
      wdata_q     <= 16'h0000;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= 32'h0000_0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0000_0000;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            op_q     <= reqOp;
            offset_q <= addr[1:0];
            wdata_q  <= wdata[15:0];
            if (isMisaligned(reqOp, addr[1:0])) begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              mem_addr_q <= {addr[ADDR_W-1:2], 2'b00};
              if (reqOp == OP_SW) begin
                mem_wdata_q <= wdata;
                mem_write_q <= 1'b1;
                state_q     <= WR;
              end else begin
                mem_read_q <= 1'b1;
                state_q    <= RD;
              end
            end
          end
        end
        RD: begin
          state_q <= CAP;
        end
        CAP: begin
          if (isLoad(op_q)) begin
            rdata_q <= laneLoad;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            mem_wdata_q <= laneMerge;
            mem_write_q <= 1'b1;
            state_q     <= WR;
          end
        end
        WR: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready     = (state_q == IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_write = mem_write_q;
  assign mem_read  = mem_read_q;

endmodule
